// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one sequential 64x64 multiplier core between two
// requesters. Round-robin arbitration between simultaneous requests, operand
// latching at grant, op_clear/op_start/op_done sequencing toward the core and
// a one-cycle done pulse with a registered product back to the winner.
// Optional build macro: MUL_ARB_FIXED_PRI_EN (port 0 always wins ties; the
// last-grant register is removed).
module mul_arbiter #(
    parameter int DATA_W = 64,
    parameter int RES_W  = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [RES_W-1:0]  result,
    output logic              busy,
    output logic              m_op_start,
    output logic              m_op_clear,
    output logic [DATA_W-1:0] m_multiplier,
    output logic [DATA_W-1:0] m_multiplicand,
    input  logic              m_op_done,
    input  logic [RES_W-1:0]  m_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        RUN   = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_gnt0;
    logic                r_gnt1;
    logic [RES_W-1:0]    r_result;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
`ifndef MUL_ARB_FIXED_PRI_EN
    logic                r_last_gnt;
`endif

    logic                w_grant0;
    logic                w_grant1;
    logic                w_capture;
    logic                w_op_clear;
    logic                w_op_start;
    logic                w_done0;
    logic                w_done1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, arbitration decision and core handshake strobes
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_capture   = 1'b0;
        w_op_clear  = 1'b0;
        w_op_start  = 1'b0;
        w_done0     = 1'b0;
        w_done1     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 && req1) begin
`ifdef MUL_ARB_FIXED_PRI_EN
                    w_grant0 = 1'b1;
`else
                    if (r_last_gnt) begin
                        w_grant0 = 1'b1;
                    end else begin
                        w_grant1 = 1'b1;
                    end
`endif
                end else if (req0) begin
                    w_grant0 = 1'b1;
                end else if (req1) begin
                    w_grant1 = 1'b1;
                end
                if (w_grant0 || w_grant1) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_op_clear  = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_op_start = 1'b1;
                if (m_op_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_done0     = r_gnt0;
                w_done1     = r_gnt1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant flags and operand latch: set at grant, grants cleared leaving RESP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_opa  <= '0;
            r_opb  <= '0;
        end else if (w_grant0) begin
            r_gnt0 <= 1'b1;
            r_gnt1 <= 1'b0;
            r_opa  <= a0;
            r_opb  <= b0;
        end else if (w_grant1) begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b1;
            r_opa  <= a1;
            r_opb  <= b1;
        end else if (r_state == RESP) begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
        end
    end

`ifndef MUL_ARB_FIXED_PRI_EN
    // Remember the most recent winner; reset to 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_gnt <= 1'b1;
        end else if (w_grant0) begin
            r_last_gnt <= 1'b0;
        end else if (w_grant1) begin
            r_last_gnt <= 1'b1;
        end
    end
`endif

    // Product register: captured on the op_done cycle, held until next capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
        end else if (w_capture) begin
            r_result <= m_result;
        end
    end

    assign gnt0           = r_gnt0;
    assign gnt1           = r_gnt1;
    assign done0          = w_done0;
    assign done1          = w_done1;
    assign result         = r_result;
    assign busy           = (r_state != IDLE);
    assign m_op_clear     = w_op_clear;
    assign m_op_start     = w_op_start;
    assign m_multiplier   = r_opa;
    assign m_multiplicand = r_opb;

endmodule
